stopwatch_ctrl: RTL and testbench

Controller that sequences the four-digit mm:ss time chain of the display design. It owns the one-second prescaler and the run/pause/clear state machine, and generates the cascaded carries between the seconds-ones, seconds-tens, minutes-ones and minutes-tens counters. It sits between the debounced front-panel buttons and the 7-segment digit multiplexer. It replaces free-running per-digit edge counting with a single clock-enable scheme.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/digit_counter.sv | 38 +++
 rtl/stopwatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit limits for the mm:ss stopwatch
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } digits_t;

endpackage

// File: rtl/digit_counter.sv
// rtl/digit_counter.sv - one BCD digit, 0..MAX, advancing on en with carry out
module digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] count,
    output logic               carry
);

    logic [DIGIT_W-1:0] count_q;
    logic [DIGIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == MAX) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign carry = en & (count_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/clear FSM, 1 s prescaler and mm:ss chain; lap hold under STOPWATCH_LAP_EN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               running,
    output logic               lap_active,
    output logic               wrap
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    sw_state_e  state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic       ss_btn_q, clr_btn_q, arm_q;
    logic       running_q, running_d;
    logic       wrap_q, wrap_d;
    logic       ss_ev, clr_ev, tick;
    logic       so_carry, st_carry, mo_carry, mt_carry;
    digits_t    live;

    // arm_q masks the first edge after reset so a button already held produces no event
    always_comb begin
        ss_ev  = arm_q & start_stop & ~ss_btn_q;
        clr_ev = arm_q & clear & ~clr_btn_q;

        state_d = state_q;
        if (clr_ev) begin
            state_d = IDLE;
        end else if (ss_ev) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end

        tick    = (state_q == RUN) && (presc_q == PRE_LAST) && !clr_ev;
        presc_d = presc_q;
        if (clr_ev) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
        end

        running_d = (state_d == RUN);
        wrap_d    = mt_carry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ss_btn_q  <= 1'b0;
            clr_btn_q <= 1'b0;
            arm_q     <= 1'b0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ss_btn_q  <= start_stop;
            clr_btn_q <= clear;
            arm_q     <= 1'b1;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .en(tick), .clr(clr_ev),
        .count(live.sec_ones), .carry(so_carry)
    );
    digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .en(so_carry), .clr(clr_ev),
        .count(live.sec_tens), .carry(st_carry)
    );
    digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .en(st_carry), .clr(clr_ev),
        .count(live.min_ones), .carry(mo_carry)
    );
    digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .en(mo_carry), .clr(clr_ev),
        .count(live.min_tens), .carry(mt_carry)
    );

    digits_t shown;

`ifdef STOPWATCH_LAP_EN
    logic    lap_btn_q;
    logic    lap_ev;
    logic    lap_active_q, lap_active_d;
    digits_t hold_q, hold_d;

    // lap acts on the resolved next state, so a lap in the resume cycle counts as RUN
    always_comb begin
        lap_ev       = arm_q & lap & ~lap_btn_q;
        lap_active_d = lap_active_q;
        hold_d       = hold_q;
        if (clr_ev) begin
            lap_active_d = 1'b0;
        end else if (lap_ev && (state_d == RUN)) begin
            lap_active_d = ~lap_active_q;
            if (!lap_active_q) begin
                hold_d = live;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_btn_q    <= 1'b0;
            lap_active_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            lap_btn_q    <= lap;
            lap_active_q <= lap_active_d;
            hold_q       <= hold_d;
        end
    end

    assign shown      = lap_active_q ? hold_q : live;
    assign lap_active = lap_active_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign shown      = live;
    assign lap_active = 1'b0;
`endif

    assign sec_ones = shown.sec_ones;
    assign sec_tens = shown.sec_tens;
    assign min_ones = shown.min_ones;
    assign min_tens = shown.min_tens;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed checks of stopwatch_ctrl with TICK_DIV=4
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_active, wrap;

    int n_total = 0;
    int n_bad = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_time(input string tag, input int mt, input int mo, input int st, input int so);
        chk({tag, ".min_tens"}, 32'(min_tens), 32'(mt));
        chk({tag, ".min_ones"}, 32'(min_ones), 32'(mo));
        chk({tag, ".sec_tens"}, 32'(sec_tens), 32'(st));
        chk({tag, ".sec_ones"}, 32'(sec_ones), 32'(so));
    endtask

    initial begin
        start_stop = 1'b1;
        #12;
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.running", 32'(running), 0);
        chk("reset.lap_active", 32'(lap_active), 0);
        chk("reset.wrap", 32'(wrap), 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3);
        chk("held_at_reset.running", 32'(running), 0);
        start_stop = 1'b0;
        step(2);

        // start: event edge E1, ticks every 4 edges; button held for 50 cycles
        start_stop = 1'b1;
        step(1);
        chk("start.running", 32'(running), 1);
        step(3);
        chk("start.e3", 32'(sec_ones), 0);
        step(1);
        chk("start.e4", 32'(sec_ones), 1);
        step(4);
        chk("start.e8", 32'(sec_ones), 2);
        step(31);
        chk_time("at_09", 0, 0, 0, 9);
        step(1);
        chk_time("at_10", 0, 0, 1, 0);
        step(10);
        chk_time("held50", 0, 0, 1, 2);
        chk("held50.running", 32'(running), 1);
        start_stop = 1'b0;
        step(2350);
        chk_time("at_1000", 1, 0, 0, 0);
        step(11999);
        chk_time("at_5959", 5, 9, 5, 9);
        chk("at_5959.wrap", 32'(wrap), 0);
        step(1);
        chk_time("wrapped", 0, 0, 0, 0);
        chk("wrapped.wrap", 32'(wrap), 1);
        step(1);
        chk("after_wrap.wrap", 32'(wrap), 0);
        chk("after_wrap.running", 32'(running), 1);

        // pause two cycles into a second, hold 20, resume
        step(4);
        chk("pre_pause", 32'(sec_ones), 1);
        start_stop = 1'b1;
        step(1);
        chk("pause.running", 32'(running), 0);
        start_stop = 1'b0;
        step(20);
        chk_time("paused", 0, 0, 0, 1);
        start_stop = 1'b1;
        step(1);
        chk("resume.running", 32'(running), 1);
        start_stop = 1'b0;
        step(1);
        chk("resume.r1", 32'(sec_ones), 1);
        step(1);
        chk("resume.r2", 32'(sec_ones), 2);

        // clear and start_stop together in RUN
        clear = 1'b1;
        start_stop = 1'b1;
        step(1);
        chk_time("clr_ss", 0, 0, 0, 0);
        chk("clr_ss.running", 32'(running), 0);
        clear = 1'b0;
        start_stop = 1'b0;
        step(8);
        chk("idle_stays.running", 32'(running), 0);
        chk("idle_stays.sec_ones", 32'(sec_ones), 0);

        // clear lands on the tick edge: the tick is discarded
        start_stop = 1'b1;
        step(1);
        chk("restart.running", 32'(running), 1);
        start_stop = 1'b0;
        step(3);
        chk("pre_tick_clr", 32'(sec_ones), 0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("tick_clr.sec_ones", 32'(sec_ones), 0);
        chk("tick_clr.running", 32'(running), 0);
        chk("tick_clr.wrap", 32'(wrap), 0);

        // lap
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        step(12);
        chk("pre_lap", 32'(sec_ones), 3);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
        chk("lap1.lap_active", 32'(lap_active), 1);
        chk("lap1.sec_ones", 32'(sec_ones), 3);
        step(15);
        chk("lap_hold.lap_active", 32'(lap_active), 1);
        chk_time("lap_hold", 0, 0, 0, 3);
`else
        chk("lap1.lap_active", 32'(lap_active), 0);
        chk("lap1.sec_ones", 32'(sec_ones), 3);
        step(15);
        chk("lap_hold.lap_active", 32'(lap_active), 0);
        chk_time("lap_hold", 0, 0, 0, 7);
`endif
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        chk("lap2.lap_active", 32'(lap_active), 0);
        chk_time("lap2", 0, 0, 0, 7);

        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0, 0);
        chk("async_rst.running", 32'(running), 0);
        chk("async_rst.lap_active", 32'(lap_active), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
